// File: rtl/gp_bus_pkg.sv
// Shared definitions for the general-purpose register bus master: controller
// states and the default bus geometry / IRQ clear mask.
package gp_bus_pkg;

    localparam int          GP_ADDR_W       = 10;
    localparam int          GP_DATA_W       = 32;
    localparam logic [31:0] GP_IRQ_CLR_MASK = 32'hFFFF_FFFE;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_WAIT,
        IRQ_RD,
        IRQ_WAIT,
        IRQ_CLR
    } gp_state_t;

endpackage

// File: rtl/gp_reg_master.sv
// Register-bus master: serialises local read/write requests onto a simple
// strobe bus and services a level IRQ by read-then-clear of one register.
module gp_reg_master
    import gp_bus_pkg::*;
#(
    parameter int                ADDR_W       = GP_ADDR_W,
    parameter int                DATA_W       = GP_DATA_W,
    parameter int                RD_LATENCY   = 1,
    parameter logic [ADDR_W-1:0] IRQ_ADDR     = '0,
    parameter logic [DATA_W-1:0] IRQ_CLR_MASK = DATA_W'(GP_IRQ_CLR_MASK)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    input  logic              IRQ,
    output logic              evt_valid,
    output logic [DATA_W-1:0] evt_data
);

    localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY);

    gp_state_t         state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic              read_nxt, write_nxt;
    logic [ADDR_W-1:0] address_nxt;
    logic [DATA_W-1:0] write_data_nxt;
    logic              rsp_valid_nxt, evt_valid_nxt;
    logic [DATA_W-1:0] rsp_data_nxt, evt_data_nxt;

    // IRQ has priority, so a local request is only offered the bus when IRQ is quiet.
    assign req_ready = rst_n && (state == IDLE) && !IRQ;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        read_nxt       = 1'b0;
        write_nxt      = 1'b0;
        address_nxt    = address;
        write_data_nxt = write_data;
        rsp_valid_nxt  = 1'b0;
        rsp_data_nxt   = rsp_data;
        evt_valid_nxt  = 1'b0;
        evt_data_nxt   = evt_data;

        case (state)
            IDLE: begin
                if (IRQ) begin
                    state_nxt   = IRQ_RD;
                    read_nxt    = 1'b1;
                    address_nxt = IRQ_ADDR;
                end else if (req_valid) begin
                    address_nxt = req_address;
                    if (req_write) begin
                        state_nxt      = WR;
                        write_nxt      = 1'b1;
                        write_data_nxt = req_wdata;
                    end else begin
                        state_nxt = RD;
                        read_nxt  = 1'b1;
                    end
                end
            end
            WR: begin
                rsp_valid_nxt = 1'b1;
                rsp_data_nxt  = '0;
                state_nxt     = IDLE;
            end
            RD: begin
                cnt_nxt   = LAT_INIT;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                // Expiry at 1 (not 0) samples exactly RD_LATENCY edges after the strobe.
                if (cnt <= 3'd1) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = read_data;
                    cnt_nxt       = 3'd0;
                    state_nxt     = IDLE;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            IRQ_RD: begin
                cnt_nxt   = LAT_INIT;
                state_nxt = IRQ_WAIT;
            end
            IRQ_WAIT: begin
                if (cnt <= 3'd1) begin
                    evt_data_nxt   = read_data;
                    write_nxt      = 1'b1;
                    write_data_nxt = read_data & IRQ_CLR_MASK;
                    cnt_nxt        = 3'd0;
                    state_nxt      = IRQ_CLR;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            IRQ_CLR: begin
                evt_valid_nxt = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            write_data <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            evt_valid  <= 1'b0;
            evt_data   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            read       <= read_nxt;
            write      <= write_nxt;
            address    <= address_nxt;
            write_data <= write_data_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_data   <= rsp_data_nxt;
            evt_valid  <= evt_valid_nxt;
            evt_data   <= evt_data_nxt;
        end
    end

endmodule

// File: doc/gp_reg_master.md
GP_REG_MASTER -- requirements
Module: gp_reg_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning bus data width.
REQ-003 SHALL have parameter RD_LATENCY, default 1, meaning cycles from read strobe to valid read_data (range 1..7).
REQ-004 SHALL have parameter IRQ_ADDR, default 0, meaning register address serviced on IRQ.
REQ-005 SHALL have parameter IRQ_CLR_MASK, default 32'hFFFF_FFFE, meaning AND mask applied to IRQ-register data before write-back.
REQ-006 SHALL have ports, in order:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  local request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_address  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write payload.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  DATA_W  read data; 0 for writes.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- address  out  ADDR_W  bus address.
- write_data  out  DATA_W  bus write data.
- read_data  in  DATA_W  bus read data.
- IRQ  in  1  level interrupt from target, same clock domain.
- evt_valid  out  1  one-cycle pulse: IRQ serviced.
- evt_data  out  DATA_W  IRQ-register value read during service.

Function
REQ-007 SHALL implement states IDLE, WR, RD, RD_WAIT, IRQ_RD, IRQ_WAIT, IRQ_CLR.
REQ-008 SHALL drive read, write, address, write_data from registers; read and write never high together.
REQ-009 SHALL assert req_ready only in IDLE with IRQ low; handshake = req_valid & req_ready at a rising edge.
REQ-010 IDLE: IRQ high -> IRQ_RD (priority over local request); else accepted write -> WR; accepted read -> RD.
REQ-011 WR: write=1 for exactly one cycle with latched address/data; then rsp_valid=1, rsp_data=0, -> IDLE.
REQ-012 RD: read=1 for exactly one cycle; -> RD_WAIT; down-counter loaded with RD_LATENCY.
REQ-013 RD_WAIT: sample read_data on the edge where counter expires (RD_LATENCY cycles after the read cycle); rsp_valid=1, rsp_data=sample for one cycle; -> IDLE.
REQ-014 Local read latency, handshake edge to rsp_valid high: RD_LATENCY+2 cycles; write: 2 cycles.
REQ-015 IRQ_RD/IRQ_WAIT: same timing as RD/RD_WAIT at address IRQ_ADDR; sampled value held in evt_data.
REQ-016 IRQ_CLR: write=1 one cycle, address=IRQ_ADDR, write_data=sample & IRQ_CLR_MASK; evt_valid=1 for one cycle coincident with the cycle after the write; -> IDLE.
REQ-017 IRQ still high on return to IDLE (e.g. local write re-set bit 0) SHALL trigger a new service sequence; no IRQ edge detection.
REQ-018 IRQ changes outside IDLE SHALL be ignored until IDLE; an in-flight local transaction always completes first.
REQ-019 req_valid held during IRQ service SHALL be accepted at the first IDLE cycle with IRQ low.
REQ-020 address/write_data outside strobe cycles SHALL hold last values (don't-care to target).

Reset
REQ-021 rst_n low SHALL asynchronously force state IDLE, read=0, write=0, address=0, write_data=0, rsp_valid=0, rsp_data=0, evt_valid=0, evt_data=0, counter=0, req_ready=0 during reset.
REQ-022 Reset mid-transaction SHALL abort it with no rsp_valid/evt_valid afterward; first cycle after release is IDLE.

Structure
REQ-023 Shared package gp_bus_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and IRQ_CLR_MASK default.
REQ-024 Single module; no sub-module; latency counter 3 bits inline.

Verification
REQ-025 Write 0x0000_0002 to 0x004 with RD_LATENCY=1 -> write=1 one cycle, address=0x004, write_data=0x2; rsp_valid 2 cycles after handshake, rsp_data=0.
REQ-026 Read 0x008, target returns 0xDEAD_BEEF one cycle after read -> rsp_valid 3 cycles after handshake, rsp_data=0xDEAD_BEEF; RD_LATENCY=3 -> 5 cycles.
REQ-027 Target register=0x0000_0005 drives IRQ=1 -> read of 0x000, then write 0x0000_0004 to 0x000; evt_valid pulse, evt_data=0x5; IRQ drops, no second service.
REQ-028 IRQ and req_valid rise same cycle -> service runs first; req_ready low throughout; request accepted in first IDLE cycle after IRQ clear.
REQ-029 Local write 0x1 to 0x000 -> IRQ rises -> automatic service; evt_data=0x1, target register ends 0x0.
REQ-030 rst_n low during RD_WAIT -> read/write/rsp_valid low immediately; no rsp_valid after release; next read completes normally.
